// File: rtl/core_bus_arbiter.sv
// Serialises the core instruction and data buses onto one single-beat memory bus.
// Data requests win over instruction requests; each request is latched at grant.
package core_bus_arbiter_pkg;
  localparam int unsigned BUS_ADDR_W = 64;
  localparam int unsigned BUS_DATA_W = 64;
  localparam int unsigned INSN_W     = 32;
  localparam int unsigned STRB_W     = 8;

  localparam logic [2:0] MSIZE4 = 3'b010;
  localparam logic [7:0] MLEN1  = 8'd0;

  typedef struct packed {
    logic                  valid;
    logic [BUS_ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [INSN_W-1:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic                  valid;
    logic [BUS_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [STRB_W-1:0]     strobe;
    logic [BUS_DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                  addr_ok;
    logic                  data_ok;
    logic [BUS_DATA_W-1:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    logic [2:0]            size;
    logic [BUS_ADDR_W-1:0] addr;
    logic [STRB_W-1:0]     strobe;
    logic [BUS_DATA_W-1:0] data;
    logic [7:0]            len;
    logic                  burst;
  } cbus_req_t;

  typedef struct packed {
    logic                  ready;
    logic                  last;
    logic [BUS_DATA_W-1:0] data;
  } cbus_resp_t;
endpackage

module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned IADDR_W = 64,
  parameter int unsigned DATA_W  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int unsigned HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e    state_q;
  cbus_req_t oreq_q;
  cbus_req_t i_txn;
  cbus_req_t d_txn;
  logic      done;

  // Memory-bus form of each client request, captured only at grant.
  always_comb begin
    i_txn          = '0;
    i_txn.valid    = 1'b1;
    i_txn.is_write = 1'b0;
    i_txn.size     = MSIZE4;
    i_txn.addr     = BUS_ADDR_W'(ireq.addr[IADDR_W-1:0]);
    i_txn.len      = MLEN1;
    i_txn.burst    = 1'b0;
  end

  always_comb begin
    d_txn          = '0;
    d_txn.valid    = 1'b1;
    d_txn.is_write = |dreq.strobe;
    d_txn.size     = dreq.size;
    d_txn.addr     = BUS_ADDR_W'(dreq.addr[IADDR_W-1:0]);
    d_txn.strobe   = dreq.strobe;
    d_txn.data     = dreq.data;
    d_txn.len      = MLEN1;
    d_txn.burst    = 1'b0;
  end

  // ready without last cannot end a single-beat transfer, so it is ignored.
  assign done = (state_q != IDLE) && oresp.ready && oresp.last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      oreq_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dreq.valid) begin
            state_q <= BUSY_D;
            oreq_q  <= d_txn;
          end else if (ireq.valid) begin
            state_q <= BUSY_I;
            oreq_q  <= i_txn;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state_q <= IDLE;
            oreq_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          oreq_q  <= '0;
        end
      endcase
    end
  end

  assign oreq = oreq_q;

  // Completion is reported combinationally, and only to the granted client.
  always_comb begin
    iresp = '0;
    dresp = '0;
    if (done && (state_q == BUSY_I)) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = oreq_q.addr[2] ? oresp.data[HALF_W +: INSN_W]
                                     : oresp.data[INSN_W-1:0];
    end
    if (done && (state_q == BUSY_D)) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = oresp.data;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: fetch, store, D-over-I priority,
// stall stability and mid-flight reset, with hand-computed expectations.
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  int checks;
  int errors;
  int ipulses;
  int dpulses;

  core_bus_arbiter #(.IADDR_W(64), .DATA_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .oreq  (oreq),
    .oresp (oresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic count_pulses();
    if (iresp.data_ok) ipulses++;
    if (dresp.data_ok) dpulses++;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    ipulses = 0;
    dpulses = 0;
    reset   = 1'b1;
    ireq    = '0;
    dreq    = '0;
    oresp   = '0;

    #12;
    check("rst_oreq_valid", 64'(oreq.valid), 64'd0);
    check("rst_oreq_addr", oreq.addr, 64'd0);
    check("rst_iresp", 64'(iresp.data_ok), 64'd0);
    check("rst_dresp", 64'(dresp.data_ok), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // Single fetch, upper word selected by addr[2]=1
    ireq.valid = 1'b1;
    ireq.addr  = 64'h0000_0000_8000_0004;
    #1 check("t1_idle_valid", 64'(oreq.valid), 64'd0);
    cyc();
    ireq.valid = 1'b0;
    #1;
    check("t1_valid", 64'(oreq.valid), 64'd1);
    check("t1_is_write", 64'(oreq.is_write), 64'd0);
    check("t1_size", 64'(oreq.size), 64'd2);
    check("t1_addr", oreq.addr, 64'h0000_0000_8000_0004);
    check("t1_strobe", 64'(oreq.strobe), 64'd0);
    check("t1_len", 64'(oreq.len), 64'd0);
    check("t1_no_early", 64'(iresp.data_ok), 64'd0);
    cyc();
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 64'h1111_2222_3333_4444;
    #1;
    check("t1_addr_ok", 64'(iresp.addr_ok), 64'd1);
    check("t1_data_ok", 64'(iresp.data_ok), 64'd1);
    check("t1_data", 64'(iresp.data), 64'h1111_2222);
    check("t1_dresp_quiet", 64'(dresp.data_ok), 64'd0);
    cyc();
    oresp = '0;
    #1;
    check("t1_done_valid", 64'(oreq.valid), 64'd0);
    check("t1_done_ok", 64'(iresp.data_ok), 64'd0);

    // Store, with a ready-without-last cycle that must be ignored
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h0000_0000_8000_1000;
    dreq.size   = 3'd3;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hDEAD_BEEF_0000_0001;
    cyc();
    dreq = '0;
    #1;
    check("t2_valid", 64'(oreq.valid), 64'd1);
    check("t2_is_write", 64'(oreq.is_write), 64'd1);
    check("t2_size", 64'(oreq.size), 64'd3);
    check("t2_addr", oreq.addr, 64'h0000_0000_8000_1000);
    check("t2_strobe", 64'(oreq.strobe), 64'hFF);
    check("t2_data", oreq.data, 64'hDEAD_BEEF_0000_0001);
    check("t2_len", 64'(oreq.len), 64'd0);
    check("t2_burst", 64'(oreq.burst), 64'd0);
    check("t2_no_early", 64'(dresp.data_ok), 64'd0);
    cyc();
    oresp.ready = 1'b1;
    oresp.last  = 1'b0;
    oresp.data  = 64'h0123_4567_89AB_CDEF;
    #1 check("t2_ready_no_last", 64'(dresp.data_ok), 64'd0);
    cyc();
    oresp.last = 1'b1;
    oresp.data = 64'hCAFE_F00D_1234_5678;
    #1;
    check("t2_still_busy", 64'(oreq.valid), 64'd1);
    check("t2_addr_ok", 64'(dresp.addr_ok), 64'd1);
    check("t2_data_ok", 64'(dresp.data_ok), 64'd1);
    check("t2_rdata", dresp.data, 64'hCAFE_F00D_1234_5678);
    check("t2_iresp_quiet", 64'(iresp.data_ok), 64'd0);
    cyc();
    oresp = '0;
    #1;
    check("t2_done_valid", 64'(oreq.valid), 64'd0);
    check("t2_done_ok", 64'(dresp.data_ok), 64'd0);

    // Simultaneous I and D, 3-cycle memory latency
    ipulses     = 0;
    dpulses     = 0;
    ireq.valid  = 1'b1;
    ireq.addr   = 64'h0000_0000_8000_0100;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h0000_0000_8000_2000;
    dreq.size   = 3'd1;
    dreq.strobe = 8'h0C;
    dreq.data   = 64'h0000_0000_0000_1234;
    cyc();
    dreq.valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      oresp.ready = (k == 2);
      oresp.last  = (k == 2);
      oresp.data  = 64'h0000_0000_0000_0099;
      #1;
      check("t3_d_first_addr", oreq.addr, 64'h0000_0000_8000_2000);
      if (k == 0) begin
        check("t3_d_is_write", 64'(oreq.is_write), 64'd1);
        check("t3_d_size", 64'(oreq.size), 64'd1);
      end
      count_pulses();
      cyc();
    end
    oresp = '0;
    #1;
    check("t3_bubble", 64'(oreq.valid), 64'd0);
    count_pulses();
    cyc();
    ireq.valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      oresp.ready = (k == 2);
      oresp.last  = (k == 2);
      oresp.data  = 64'hAAAA_BBBB_CCCC_DDDD;
      #1;
      check("t3_i_addr", oreq.addr, 64'h0000_0000_8000_0100);
      check("t3_i_is_write", 64'(oreq.is_write), 64'd0);
      if (k == 2) check("t3_i_data", 64'(iresp.data), 64'hCCCC_DDDD);
      count_pulses();
      cyc();
    end
    oresp = '0;
    #1;
    count_pulses();
    check("t3_i_pulses", 64'(ipulses), 64'd1);
    check("t3_d_pulses", 64'(dpulses), 64'd1);

    // Stall: D address wiggles while memory holds ready low
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h0000_0000_8000_3000;
    dreq.size   = 3'd3;
    dreq.strobe = 8'h00;
    dreq.data   = 64'd0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      dreq.addr  = 64'h0000_0000_8000_3000 + 64'((i + 1) * 8);
      dreq.valid = (i % 2) == 1;
      #1 check("t4_stable_addr", oreq.addr, 64'h0000_0000_8000_3000);
      cyc();
    end
    dreq        = '0;
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 64'h0000_0000_0000_0042;
    #1;
    check("t4_read", 64'(oreq.is_write), 64'd0);
    check("t4_data_ok", 64'(dresp.data_ok), 64'd1);
    cyc();
    oresp = '0;

    // Reset during cycle 2 of BUSY_I, then a normal minimum-latency fetch
    ireq.valid = 1'b1;
    ireq.addr  = 64'h0000_0000_8000_0008;
    cyc();
    ireq.valid = 1'b0;
    cyc();
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 64'h9999_9999_9999_9999;
    #1 check("t5_busy_before_rst", 64'(oreq.valid), 64'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_valid", 64'(oreq.valid), 64'd0);
    check("t5_rst_data_ok", 64'(iresp.data_ok), 64'd0);
    check("t5_rst_data", 64'(iresp.data), 64'd0);
    cyc();
    check("t5_rst_hold", 64'(oreq.valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    oresp = '0;
    cyc();
    ireq.valid = 1'b1;
    ireq.addr  = 64'h0000_0000_8000_0000;
    #1 check("t5_idle", 64'(oreq.valid), 64'd0);
    cyc();
    ireq.valid  = 1'b0;
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 64'h5555_6666_7777_8888;
    #1;
    check("t5_valid", 64'(oreq.valid), 64'd1);
    check("t5_addr", oreq.addr, 64'h0000_0000_8000_0000);
    check("t5_data_ok", 64'(iresp.data_ok), 64'd1);
    check("t5_data", 64'(iresp.data), 64'h7777_8888);
    cyc();
    oresp = '0;
    #1 check("t5_done_valid", 64'(oreq.valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
